// File: rtl/dmem_pkg.sv
// dmem_pkg
// Shared encodings and helpers for the data-memory lane controller:
//   - access size encodings (byte / half / word / reserved)
//   - controller state encoding
//   - lane_of(): which byte lane serves byte i of an access
//   - bytes_used(): which access bytes (0..3) a given size touches
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  localparam logic [1:0] SZ_RSVD = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  // Byte i of an access starting at byte offset addr_lo lives in lane
  // (addr_lo + i) mod 4; the 2-bit add wraps naturally.
  function automatic logic [1:0] lane_of(input logic [1:0] addr_lo,
                                         input logic [1:0] i);
    return addr_lo + i;
  endfunction

  function automatic logic [3:0] bytes_used(input logic [1:0] size);
    case (size)
      SZ_BYTE: return 4'b0001;
      SZ_HALF: return 4'b0011;
      SZ_WORD: return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/dmem_load_align.sv
// dmem_load_align
// Gathers the bytes of a load from the four lane read bytes and extends
// the result to 32 bits.
//   lane_dout   : lane L read byte in [8L+:8]
//   offset      : byte offset of the access within its first word
//   size        : SZ_BYTE / SZ_HALF / SZ_WORD
//   is_unsigned : 1 = zero-extend, 0 = sign-extend
//   rdata       : right-aligned, extended load value
module dmem_load_align
  import dmem_pkg::*;
(
  input  logic [31:0] lane_dout,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [31:0] rdata
);

  logic [31:0] gathered;
  logic        fill;

  // Byte i comes from lane (offset + i) mod 4, i.e. a right rotate of the
  // lane bus by offset bytes.
  always_comb begin
    case (offset)
      2'd1:    gathered = {lane_dout[7:0],  lane_dout[31:8]};
      2'd2:    gathered = {lane_dout[15:0], lane_dout[31:16]};
      2'd3:    gathered = {lane_dout[23:0], lane_dout[31:24]};
      default: gathered = lane_dout;
    endcase
  end

  always_comb begin
    fill  = 1'b0;
    rdata = gathered;
    case (size)
      SZ_BYTE: begin
        fill  = ~is_unsigned & gathered[7];
        rdata = {{24{fill}}, gathered[7:0]};
      end
      SZ_HALF: begin
        fill  = ~is_unsigned & gathered[15];
        rdata = {{16{fill}}, gathered[15:0]};
      end
      default: rdata = gathered;
    endcase
  end

endmodule

// File: rtl/dmem_lane_ctrl.sv
// dmem_lane_ctrl
// Data-memory access controller between the load/store stage and four
// byte-wide BRAM lanes (lane L holds byte L of each 32-bit word).
// A byte/half/word request is split into per-lane word addresses, strobes
// and write bytes; a load's lane bytes are merged back into an aligned,
// extended 32-bit response. Accesses crossing a word boundary finish in one
// access because every lane gets its own word address.
// Ports:
//   CLK, RESETN            clock, synchronous active-low reset
//   REQ_*                  request channel (valid/ready handshake)
//   RSP_*                  response channel (held until RSP_READY)
//   LANE_WADDR/LANE_RADDR  per-lane byte address, lane L at [L*AW +: AW]
//   LANE_WE/LANE_RE        per-lane strobes, high only in the ACCESS cycle
//   LANE_DIN/LANE_DOUT     lane L byte at [8L +: 8]
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | no request in flight, ready for a new one
// ST_ACCESS | lane strobes driven; lanes act on the negedge of this cycle
// ST_RESP   | response held on RSP_*; may accept the next request
module dmem_lane_ctrl
  import dmem_pkg::*;
#(
  parameter int          ADDR_WIDTH       = 13,
  parameter int unsigned DEPTH_WORDS      = 1024,
  parameter bit          ALLOW_MISALIGNED = 1'b1
) (
  input  logic                    CLK,
  input  logic                    RESETN,
  input  logic                    REQ_VALID,
  output logic                    REQ_READY,
  input  logic                    REQ_WE,
  input  logic [ADDR_WIDTH-1:0]   REQ_ADDR,
  input  logic [1:0]              REQ_SIZE,
  input  logic                    REQ_UNSIGNED,
  input  logic [31:0]             REQ_WDATA,
  output logic                    RSP_VALID,
  input  logic                    RSP_READY,
  output logic [31:0]             RSP_RDATA,
  output logic                    RSP_ERR,
  output logic [4*ADDR_WIDTH-1:0] LANE_WADDR,
  output logic [4*ADDR_WIDTH-1:0] LANE_RADDR,
  output logic [3:0]              LANE_WE,
  output logic [3:0]              LANE_RE,
  output logic [31:0]             LANE_DIN,
  input  logic [31:0]             LANE_DOUT
);

  localparam int AW = ADDR_WIDTH;

  state_e                 state_q, state_d;
  logic                   rsp_valid_q, rsp_valid_d;
  logic                   rsp_err_q, rsp_err_d;
  logic [31:0]            rsp_rdata_q, rsp_rdata_d;
  logic [3:0]             lane_we_q, lane_we_d;
  logic [3:0]             lane_re_q, lane_re_d;
  logic [3:0][AW-1:0]     lane_waddr_q, lane_waddr_d;
  logic [3:0][AW-1:0]     lane_raddr_q, lane_raddr_d;
  logic [3:0][7:0]        lane_din_q, lane_din_d;
  logic [1:0]             acc_off_q, acc_off_d;
  logic [1:0]             acc_size_q, acc_size_d;
  logic                   acc_uns_q, acc_uns_d;
  logic                   acc_we_q, acc_we_d;

  logic [3:0]             used_mask;
  logic                   misaligned;
  logic                   req_err;
  logic                   carry;
  // Word index of each access byte, one bit wider than the address word
  // field so a run past the top of the address space shows up as overflow.
  logic [AW-2:0]          byte_word [4];
  logic [1:0]             byte_lane [4];
  logic [3:0][7:0]        wdata_bytes;
  logic                   req_ready;
  logic                   accept;
  logic [31:0]            load_data;

  assign wdata_bytes = REQ_WDATA;
  assign req_ready   = (state_q == ST_IDLE) || ((state_q == ST_RESP) && RSP_READY);
  assign accept      = REQ_VALID && req_ready;

  // Request decode: per-byte lane and word, plus the error conditions.
  always_comb begin
    used_mask  = bytes_used(REQ_SIZE);
    misaligned = ((REQ_SIZE == SZ_HALF) && REQ_ADDR[0]) ||
                 ((REQ_SIZE == SZ_WORD) && (REQ_ADDR[1:0] != 2'b00));
    req_err    = (REQ_SIZE == SZ_RSVD) || (!ALLOW_MISALIGNED && misaligned);
    carry      = 1'b0;
    for (int i = 0; i < 4; i++) begin
      carry        = (int'(REQ_ADDR[1:0]) + i) > 3;
      byte_word[i] = {1'b0, REQ_ADDR[AW-1:2]} + {{(AW-2){1'b0}}, carry};
      byte_lane[i] = lane_of(REQ_ADDR[1:0], 2'(i));
      if (used_mask[i] &&
          (byte_word[i][AW-2] || (32'(byte_word[i]) >= DEPTH_WORDS)))
        req_err = 1'b1;
    end
  end

  dmem_load_align u_load_align (
    .lane_dout   (LANE_DOUT),
    .offset      (acc_off_q),
    .size        (acc_size_q),
    .is_unsigned (acc_uns_q),
    .rdata       (load_data)
  );

  always_comb begin
    state_d      = state_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_err_d    = rsp_err_q;
    rsp_rdata_d  = rsp_rdata_q;
    lane_we_d    = '0;
    lane_re_d    = '0;
    lane_waddr_d = lane_waddr_q;
    lane_raddr_d = lane_raddr_q;
    lane_din_d   = lane_din_q;
    acc_off_d    = acc_off_q;
    acc_size_d   = acc_size_q;
    acc_uns_d    = acc_uns_q;
    acc_we_d     = acc_we_q;

    case (state_q)
      ST_ACCESS: begin
        // Lanes were read on the negedge; LANE_DOUT is settled here.
        state_d     = ST_RESP;
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = acc_we_q ? 32'h0 : load_data;
      end
      ST_RESP: begin
        if (RSP_READY) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = 32'h0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A new request overrides the RESP->IDLE transition (back-to-back).
    if (accept) begin
      if (req_err) begin
        state_d     = ST_RESP;
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b1;
        rsp_rdata_d = 32'h0;
      end else begin
        state_d     = ST_ACCESS;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = 32'h0;
        acc_off_d   = REQ_ADDR[1:0];
        acc_size_d  = REQ_SIZE;
        acc_uns_d   = REQ_UNSIGNED;
        acc_we_d    = REQ_WE;
        for (int i = 0; i < 4; i++) begin
          if (used_mask[i]) begin
            if (REQ_WE) begin
              lane_we_d[byte_lane[i]]    = 1'b1;
              lane_waddr_d[byte_lane[i]] = {byte_word[i][AW-3:0], 2'b00};
              lane_din_d[byte_lane[i]]   = wdata_bytes[i];
            end else begin
              lane_re_d[byte_lane[i]]    = 1'b1;
              lane_raddr_d[byte_lane[i]] = {byte_word[i][AW-3:0], 2'b00};
            end
          end
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      state_q      <= ST_IDLE;
      rsp_valid_q  <= 1'b0;
      rsp_err_q    <= 1'b0;
      rsp_rdata_q  <= 32'h0;
      lane_we_q    <= '0;
      lane_re_q    <= '0;
      lane_waddr_q <= '0;
      lane_raddr_q <= '0;
      lane_din_q   <= '0;
      acc_off_q    <= 2'b00;
      acc_size_q   <= SZ_BYTE;
      acc_uns_q    <= 1'b0;
      acc_we_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_err_q    <= rsp_err_d;
      rsp_rdata_q  <= rsp_rdata_d;
      lane_we_q    <= lane_we_d;
      lane_re_q    <= lane_re_d;
      lane_waddr_q <= lane_waddr_d;
      lane_raddr_q <= lane_raddr_d;
      lane_din_q   <= lane_din_d;
      acc_off_q    <= acc_off_d;
      acc_size_q   <= acc_size_d;
      acc_uns_q    <= acc_uns_d;
      acc_we_q     <= acc_we_d;
    end
  end

  assign REQ_READY  = req_ready;
  assign RSP_VALID  = rsp_valid_q;
  assign RSP_ERR    = rsp_err_q;
  assign RSP_RDATA  = rsp_rdata_q;
  assign LANE_WE    = lane_we_q;
  assign LANE_RE    = lane_re_q;
  assign LANE_WADDR = lane_waddr_q;
  assign LANE_RADDR = lane_raddr_q;
  assign LANE_DIN   = lane_din_q;

endmodule
